// File: rtl/snitch_icache_event_counters.sv
// Cluster-wide icache event counters (miss/hit/prefetch/double_hit/stall) with sticky overflow flags.
// Counts are visible 1+REG_EVENTS cycles after the events; reads return data one cycle after accept.
package snitch_icache_event_pkg;
  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
    logic l0_stall;
  } icache_events_t;
endpackage

module snitch_icache_event_counters
  import snitch_icache_event_pkg::*;
#(
  parameter int NR_FETCH_PORTS = 4,
  parameter int CNT_WIDTH      = 32,
  parameter bit SATURATE       = 1'b1,
  parameter bit REG_EVENTS     = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 enable_i,
  input  logic                                 clear_i,
  input  icache_events_t [NR_FETCH_PORTS-1:0]  events_i,
  input  logic                                 rd_valid_i,
  output logic                                 rd_ready_o,
  input  logic [2:0]                           rd_addr_i,
  output logic                                 rd_rvalid_o,
  input  logic                                 rd_rready_i,
  output logic [CNT_WIDTH-1:0]                 rd_rdata_o,
  output logic                                 rd_err_o
);

  localparam int NEV   = 5;
  localparam int INC_W = $clog2(NR_FETCH_PORTS + 1);

  logic [NR_FETCH_PORTS-1:0][NEV-1:0] w_ev_masked;
  logic [NR_FETCH_PORTS-1:0][NEV-1:0] w_ev_cnt;
  logic [NEV-1:0][INC_W-1:0]          w_inc;
  logic [NEV-1:0][CNT_WIDTH:0]        w_sum;
  logic [NEV-1:0][CNT_WIDTH-1:0]      r_cnt;
  logic [NEV-1:0]                     r_ovf;
  logic [CNT_WIDTH-1:0]               w_rdata;
  logic                               w_err;
  logic                               r_rvalid;
  logic [CNT_WIDTH-1:0]               r_rdata;
  logic                               r_err;

  // Bit k of each port vector is counter k (0=miss .. 4=stall), matching the read address map.
  always_comb begin
    w_ev_masked = '0;
    for (int p = 0; p < NR_FETCH_PORTS; p++) begin
      w_ev_masked[p] = {events_i[p].l0_stall, events_i[p].l0_double_hit, events_i[p].l0_prefetch,
                        events_i[p].l0_hit, events_i[p].l0_miss} & {NEV{enable_i}};
    end
  end

  if (REG_EVENTS) begin : g_reg
    logic [NR_FETCH_PORTS-1:0][NEV-1:0] r_ev;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_ev <= '0;
      end else begin
        r_ev <= clear_i ? '0 : w_ev_masked;
      end
    end
    assign w_ev_cnt = r_ev;
  end else begin : g_comb
    assign w_ev_cnt = w_ev_masked;
  end

  always_comb begin
    w_inc = '0;
    w_sum = '0;
    for (int k = 0; k < NEV; k++) begin
      for (int p = 0; p < NR_FETCH_PORTS; p++) begin
        w_inc[k] = w_inc[k] + INC_W'(w_ev_cnt[p][k]);
      end
      w_sum[k] = {1'b0, r_cnt[k]} + {{(CNT_WIDTH + 1 - INC_W){1'b0}}, w_inc[k]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else begin
      for (int k = 0; k < NEV; k++) begin
        if (w_sum[k][CNT_WIDTH]) begin
          r_ovf[k] <= 1'b1;
          r_cnt[k] <= SATURATE ? {CNT_WIDTH{1'b1}} : w_sum[k][CNT_WIDTH-1:0];
        end else begin
          r_cnt[k] <= w_sum[k][CNT_WIDTH-1:0];
        end
      end
    end
  end

  // Read mux samples the pre-update counters, so an accept in a count/clear cycle sees old values.
  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (rd_addr_i)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: w_rdata = r_cnt[rd_addr_i];
      3'd5:                         w_rdata = {{(CNT_WIDTH - NEV){1'b0}}, r_ovf};
      default:                      w_err   = 1'b1;
    endcase
  end

  assign rd_ready_o = !r_rvalid || rd_rready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (rd_valid_i && rd_ready_o) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdata;
      r_err    <= w_err;
    end else if (rd_rready_i) begin
      r_rvalid <= 1'b0;
    end
  end

  assign rd_rvalid_o = r_rvalid;
  assign rd_rdata_o  = r_rdata;
  assign rd_err_o    = r_err;

endmodule

// File: tb/tb_snitch_icache_event_counters.sv
// Two 8-bit instances share stimulus: [0] saturating with registered events, [1] wrapping and unregistered.
// A per-cycle reference model plus literal directed expectations check both.
module tb_snitch_icache_event_counters;
  import snitch_icache_event_pkg::*;

  localparam logic [1:0] M_REG = 2'b01;
  localparam logic [1:0] M_SAT = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic [4:0][3:0] evb = '0;
  icache_events_t [3:0] ev;
  logic rd_valid = 1'b0;
  logic [2:0] rd_addr = '0;
  logic rd_rready = 1'b0;
  logic [1:0] dut_rdy, dut_rv, dut_err;
  logic [1:0][7:0] dut_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    ev = '0;
    for (int p = 0; p < 4; p++) begin
      ev[p].l0_miss       = evb[0][p];
      ev[p].l0_hit        = evb[1][p];
      ev[p].l0_prefetch   = evb[2][p];
      ev[p].l0_double_hit = evb[3][p];
      ev[p].l0_stall      = evb[4][p];
    end
  end

  snitch_icache_event_counters #(.NR_FETCH_PORTS(4), .CNT_WIDTH(8), .SATURATE(1'b1), .REG_EVENTS(1'b1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear), .events_i(ev),
    .rd_valid_i(rd_valid), .rd_ready_o(dut_rdy[0]), .rd_addr_i(rd_addr), .rd_rvalid_o(dut_rv[0]),
    .rd_rready_i(rd_rready), .rd_rdata_o(dut_rdata[0]), .rd_err_o(dut_err[0]));

  snitch_icache_event_counters #(.NR_FETCH_PORTS(4), .CNT_WIDTH(8), .SATURATE(1'b0), .REG_EVENTS(1'b0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear), .events_i(ev),
    .rd_valid_i(rd_valid), .rd_ready_o(dut_rdy[1]), .rd_addr_i(rd_addr), .rd_rvalid_o(dut_rv[1]),
    .rd_rready_i(rd_rready), .rd_rdata_o(dut_rdata[1]), .rd_err_o(dut_err[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer counters, a one-deep event delay for the registered instance.
  int   m_cnt[2][5];
  bit   m_ovf[2][5];
  int   m_pend[2][5];
  bit   m_rv[2];
  logic [7:0] m_rdat[2];
  bit   m_err[2];

  function automatic int cur_inc(int k);
    return enable ? $countones(evb[k]) : 0;
  endfunction

  function automatic logic [7:0] mval(int i, int a);
    logic [7:0] v;
    v = '0;
    if (a < 5) v = 8'(m_cnt[i][a]);
    else if (a == 5) for (int k = 0; k < 5; k++) v[k] = m_ovf[i][k];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_rv[i] = 0; m_rdat[i] = '0; m_err[i] = 0;
        for (int k = 0; k < 5; k++) begin
          m_cnt[i][k] = 0; m_ovf[i][k] = 0; m_pend[i][k] = 0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rd_valid && (!m_rv[i] || rd_rready)) begin
          m_rv[i] = 1; m_rdat[i] = mval(i, int'(rd_addr)); m_err[i] = (rd_addr > 3'd5);
        end else if (rd_rready) begin
          m_rv[i] = 0;
        end
        for (int k = 0; k < 5; k++) begin
          int inc, s;
          inc = M_REG[i] ? m_pend[i][k] : cur_inc(k);
          if (clear) begin
            m_cnt[i][k] = 0; m_ovf[i][k] = 0;
          end else begin
            s = m_cnt[i][k] + inc;
            if (s > 255) begin
              m_ovf[i][k] = 1;
              m_cnt[i][k] = M_SAT[i] ? 255 : s - 256;
            end else begin
              m_cnt[i][k] = s;
            end
          end
          m_pend[i][k] = clear ? 0 : cur_inc(k);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("model_ready[%0d]", i), 32'(dut_rdy[i]), 32'(!m_rv[i] || rd_rready));
          chk($sformatf("model_rvalid[%0d]", i), 32'(dut_rv[i]), 32'(m_rv[i]));
          if (m_rv[i]) begin
            chk($sformatf("model_rdata[%0d]", i), 32'(dut_rdata[i]), 32'(m_rdat[i]));
            chk($sformatf("model_err[%0d]", i), 32'(dut_err[i]), 32'(m_err[i]));
          end
        end
      end
    end
  end

  task automatic rd(input logic [2:0] a, output logic [7:0] d0, output logic [7:0] d1, output logic e0,
                    output logic e1);
    rd_valid = 1'b1; rd_addr = a; rd_rready = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    chk("rd_rvalid", 32'(dut_rv), 32'h3);
    d0 = dut_rdata[0]; d1 = dut_rdata[1]; e0 = dut_err[0]; e1 = dut_err[1];
  endtask

  task automatic rd_exp(input string nm, input logic [2:0] a, input logic [7:0] x0, input logic [7:0] x1,
                        input logic xe);
    logic [7:0] d0, d1;
    logic e0, e1;
    rd(a, d0, d1, e0, e1);
    chk({nm, "_d0"}, 32'(d0), 32'(x0));
    chk({nm, "_d1"}, 32'(d1), 32'(x1));
    chk({nm, "_e0"}, 32'(e0), 32'(xe));
    chk({nm, "_e1"}, 32'(e1), 32'(xe));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_ready", 32'(dut_rdy), 32'h3);
    chk("reset_rvalid", 32'(dut_rv), 32'h0);
    chk("reset_rdata", 32'(dut_rdata), 32'h0);
    chk("reset_err", 32'(dut_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_ready", 32'(dut_rdy), 32'h3);
    for (int a = 0; a < 6; a++) rd_exp($sformatf("idle_addr%0d", a), 3'(a), 8'd0, 8'd0, 1'b0);

    // 4 hits + 2 misses in one cycle; read one cycle later sees only the unregistered instance updated
    evb[1] = 4'hF; evb[0] = 4'b0011;
    @(negedge clk);
    evb = '0;
    rd_exp("hit_early", 3'd1, 8'd0, 8'd4, 1'b0);
    rd_exp("hit", 3'd1, 8'd4, 8'd4, 1'b0);
    rd_exp("miss", 3'd0, 8'd2, 8'd2, 1'b0);

    pulse_clear();
    for (int c = 0; c < 64; c++) begin
      evb[1] = 4'hF;
      @(negedge clk);
    end
    evb = '0;
    repeat (2) @(negedge clk);
    rd_exp("hit_sat_wrap", 3'd1, 8'd255, 8'd0, 1'b0);
    rd_exp("ovf_hit", 3'd5, 8'h02, 8'h02, 1'b0);

    pulse_clear();
    evb[4] = 4'b0111;
    repeat (2) @(negedge clk);
    evb = '0;
    repeat (2) @(negedge clk);
    clear = 1'b1; evb[4] = 4'b0111;
    rd_exp("stall_preclear", 3'd4, 8'd6, 8'd6, 1'b0);
    clear = 1'b0; evb = '0;
    repeat (2) @(negedge clk);
    rd_exp("stall_cleared", 3'd4, 8'd0, 8'd0, 1'b0);
    rd_exp("ovf_cleared", 3'd5, 8'd0, 8'd0, 1'b0);

    evb[0] = 4'b0111;
    @(negedge clk);
    evb = '0;
    repeat (2) @(negedge clk);
    rd_valid = 1'b1; rd_addr = 3'd0; rd_rready = 1'b0;
    @(negedge clk);
    rd_addr = 3'd1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready", 32'(dut_rdy), 32'h0);
      chk("bp_rvalid", 32'(dut_rv), 32'h3);
      chk("bp_rdata0", 32'(dut_rdata[0]), 32'd3);
      chk("bp_rdata1", 32'(dut_rdata[1]), 32'd3);
      chk("bp_err", 32'(dut_err), 32'h0);
      @(negedge clk);
    end
    rd_rready = 1'b1;
    @(negedge clk);
    chk("b2b_first_rvalid", 32'(dut_rv), 32'h3);
    chk("b2b_first_rdata", 32'(dut_rdata), 32'h0000);
    rd_addr = 3'd0;
    @(negedge clk);
    rd_valid = 1'b0;
    chk("b2b_second_rvalid", 32'(dut_rv), 32'h3);
    chk("b2b_second_rdata", 32'(dut_rdata), 32'h0303);
    @(negedge clk);
    chk("b2b_drained", 32'(dut_rv), 32'h0);

    rd_exp("addr6", 3'd6, 8'd0, 8'd0, 1'b1);
    rd_exp("addr7", 3'd7, 8'd0, 8'd0, 1'b1);

    evb[2] = 4'b0011;
    @(negedge clk);
    enable = 1'b0; evb[2] = 4'hF;
    repeat (20) @(negedge clk);
    evb = '0; enable = 1'b1;
    repeat (2) @(negedge clk);
    rd_exp("prefetch_masked", 3'd2, 8'd2, 8'd2, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 5; k++) evb[k] = 4'($urandom_range(0, 15));
      enable    = ($urandom % 8) != 0;
      clear     = ($urandom % 150) == 0;
      rd_valid  = ($urandom % 2) != 0;
      rd_addr   = 3'($urandom % 8);
      rd_rready = ($urandom % 4) != 0;
      @(negedge clk);
    end
    evb = '0; clear = 1'b0; rd_valid = 1'b0; rd_rready = 1'b1; enable = 1'b1;
    repeat (3) @(negedge clk);

    rd_valid = 1'b1; rd_addr = 3'd1; rd_rready = 1'b0;
    @(negedge clk);
    rd_valid = 1'b0;
    chk("pre_rst_rvalid", 32'(dut_rv), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(dut_rv), 32'h0);
    chk("mid_rst_ready", 32'(dut_rdy), 32'h3);
    chk("mid_rst_rdata", 32'(dut_rdata), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_exp("post_rst_hit", 3'd1, 8'd0, 8'd0, 1'b0);
    rd_exp("post_rst_ovf", 3'd5, 8'd0, 8'd0, 1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
